// File: rtl/accum_mem_pkg.sv
// Shared types and limits for the memory arbiter and its latency counter.
package accum_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;
  localparam int CNT_W   = 3;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable 3-bit down-counter that paces the read-latency wait.
module mem_lat_counter
  import accum_mem_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory with a
// fixed read latency; each transaction ends with a one-cycle ack.
module mem_arbiter
  import accum_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LAT    = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Out-of-range latencies are clamped so the counter load always fits.
  localparam int LAT_C = (LAT < LAT_MIN) ? LAT_MIN : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT_C - 1);

  arb_state_e        state_q;
  logic              grant_q, grant_d, last_grant_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;
  logic              cpu_ack_q, ext_ack_q, mem_en_q, mem_we_q;
  logic              cnt_load, cnt_dec, cnt_zero;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant_d = PORT_CPU;
    if (cpu_req && ext_req) begin
      grant_d = ~last_grant_q;
    end else if (ext_req) begin
      grant_d = PORT_EXT;
    end
  end

  assign cnt_load = (state_q == ST_ACCESS) && !we_q;
  assign cnt_dec  = (state_q == ST_WAIT);

  mem_lat_counter u_lat_cnt (
    .CLK    (CLK),
    .Reset  (Reset),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .val_i  (LOAD_VAL),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= PORT_CPU;
      last_grant_q <= PORT_EXT;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      ext_ack_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      ext_ack_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req || ext_req) begin
            grant_q  <= grant_d;
            we_q     <= (grant_d == PORT_EXT) ? ext_we    : cpu_we;
            addr_q   <= (grant_d == PORT_EXT) ? ext_addr  : cpu_addr;
            wdata_q  <= (grant_d == PORT_EXT) ? ext_wdata : cpu_wdata;
            mem_en_q <= 1'b1;
            mem_we_q <= (grant_d == PORT_EXT) ? ext_we    : cpu_we;
            state_q  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            cpu_ack_q <= (grant_q == PORT_CPU);
            ext_ack_q <= (grant_q == PORT_EXT);
            state_q   <= ST_DONE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            if (grant_q == PORT_EXT) begin
              ext_rdata_q <= mem_rdata;
            end else begin
              cpu_rdata_q <= mem_rdata;
            end
            cpu_ack_q <= (grant_q == PORT_CPU);
            ext_ack_q <= (grant_q == PORT_EXT);
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_grant_q <= grant_q;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter LAT, default 1, read latency in cycles from mem_en to valid mem_rdata; legal range 1..7.
REQ-004 SHALL have port CLK, input, 1, clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports cpu_req, input, 1, and cpu_we, input, 1: control-unit access request and write select.
REQ-007 SHALL have ports cpu_addr, input, ADDR_W, and cpu_wdata, input, DATA_W: control-unit address and write data.
REQ-008 SHALL have ports cpu_rdata, output, DATA_W, and cpu_ack, output, 1: control-unit read data and completion pulse.
REQ-009 SHALL have ports ext_req, ext_we, ext_addr, ext_wdata, ext_rdata and ext_ack, with the same directions and widths as the cpu_* set, for the external loader/debug port.
REQ-010 SHALL have ports mem_en, output, 1; mem_we, output, 1; mem_addr, output, ADDR_W; mem_wdata, output, DATA_W; and mem_rdata, input, DATA_W: the single-port memory interface.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL implement the states IDLE, ACCESS, WAIT and DONE.
REQ-013 SHALL sample requests only in IDLE; a request pending in IDLE moves the block to ACCESS on the next edge.
REQ-014 SHALL grant the single requester when only one of cpu_req and ext_req is high.
REQ-015 SHALL, when both requests are high in IDLE, grant the port not granted last (round-robin); last_grant resets to EXT, so the CPU wins the first tie.
REQ-016 SHALL latch the granted port id, addr, we and wdata on the IDLE->ACCESS edge; later changes on the requester inputs are ignored until DONE.
REQ-017 SHALL drive, in ACCESS only: mem_en=1, mem_we=latched we, mem_addr=latched addr, mem_wdata=latched wdata.
REQ-018 SHALL keep mem_en and mem_we at 0 in all other states; mem_addr and mem_wdata hold their latched values.
REQ-019 SHALL, for a write, go ACCESS->DONE.
REQ-020 SHALL, for a read, load the wait counter with LAT-1 and go ACCESS->WAIT.
REQ-021 SHALL, in WAIT, decrement the counter while it is nonzero; at zero it captures mem_rdata into the granted port's rdata register and goes to DONE.
REQ-022 SHALL, in DONE, pulse the granted port's ack high for exactly one cycle, update last_grant, and go to IDLE.
REQ-023 SHALL give a read a latency of LAT+2 cycles and a write a latency of 2 cycles, measured from the IDLE cycle sampling req to the ack cycle.
REQ-024 SHALL hold each port's rdata until that port's next read capture; writes and the other port's transactions leave it unchanged.
REQ-025 SHALL complete a transaction and pulse ack even if the requester deasserts req mid-transaction.
REQ-026 SHALL treat a req still high in the IDLE cycle after DONE as a new request; requesters drop req on the edge after ack.
REQ-027 SHALL never assert cpu_ack and ext_ack in the same cycle.

Reset
REQ-028 SHALL, while Reset is high, force state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ack=0, ext_ack=0, cpu_rdata=0, ext_rdata=0, busy=0, counter=0 and last_grant=EXT.
REQ-029 SHALL, on a Reset asserted mid-transaction, abort the transaction with no ack, and perform the first arbitration on the first rising CLK edge after Reset falls.

Structure
REQ-030 SHALL take the state encoding, port-id constants (CPU=0, EXT=1), DATA_W/ADDR_W defaults and the LAT range limit from shared package accum_mem_pkg.
REQ-031 SHALL place the loadable down-counter in one sub-module, mem_lat_counter (load, decrement, zero flag, 3 bits).

Verification
REQ-032 SHALL cover: LAT=1, CPU read of addr 0x0010 with memory returning 0xBEEF -> cpu_ack at cycle 3, cpu_rdata=0xBEEF, mem_en high in cycle 1 only.
REQ-033 SHALL cover: EXT write addr 0x0020 data 0x1234 -> mem_we=1 in cycle 1 with those values, ext_ack in cycle 2, cpu_rdata unchanged.
REQ-034 SHALL cover: cpu_req and ext_req both rise in the same cycle after reset -> CPU served first; EXT granted in the IDLE after the CPU ack; the next tie goes to CPU.
REQ-035 SHALL cover: LAT=4 read -> ack at cycle 6, with 3 WAIT cycles before capture.
REQ-036 SHALL cover: Reset pulsed while in WAIT -> no ack, all outputs 0, and the next CPU read completes normally.
REQ-037 SHALL cover: cpu_req dropped during ACCESS -> cpu_ack still pulses once; no second transaction starts.
